// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU data port to N_DEV memory-mapped slots with wait states, bus timeout and irq aggregation.
// Optional SYS_BRIDGE_IRQ_LATCH_EN: edge-latched pending irqs with a mask register in the ctrl region.
module sys_bridge_n #(
  parameter int          N_DEV     = 2,
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter int          SPAN_LOG2 = 4,
  parameter int          TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wd,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [31:0]          cpu_rd,
  output logic                 cpu_stall,
  output logic [5:0]           cpu_intr,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wd,
  output logic [N_DEV-1:0]     dev_we,
  output logic [N_DEV-1:0]     dev_re,
  input  logic [32*N_DEV-1:0]  dev_rd,
  input  logic [N_DEV-1:0]     dev_ready,
  input  logic [N_DEV-1:0]     dev_irq
);
  localparam int SW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt;
  logic [SW-1:0]          sel;
  logic                   dir_we, st_err, st_to;
  logic [31:0]            addr_q, wd_q, rdata, ctrl_rdata;
  logic [N_DEV-1:0][31:0] rd_arr;
  logic [N_DEV-1:0]       sel_oh, intr_src;
  logic                   accept, finish_ok, finish_to, strobe;

  // Address decode: slots first, then one slot-sized ctrl region right after them.
  logic [31:0] ofs, slot_idx, loc;
  logic [29:0] wofs;
  logic        in_rng, slot_hit, ctrl_hit, req, idle, ctrl_we, ctrl_re, miss;
  assign in_rng   = cpu_addr >= DEV_BASE;
  assign ofs      = cpu_addr - DEV_BASE;
  assign slot_idx = ofs >> SPAN_LOG2;
  assign loc      = ofs & ((32'd1 << SPAN_LOG2) - 32'd1);
  assign wofs     = 30'(loc >> 2);
  assign slot_hit = in_rng && (slot_idx < 32'(N_DEV));
  assign ctrl_hit = in_rng && (slot_idx == 32'(N_DEV));
  assign req      = cpu_we | cpu_re;
  assign idle     = (state == IDLE);
  assign ctrl_we  = idle && ctrl_hit && cpu_we;
  assign ctrl_re  = idle && ctrl_hit && !cpu_we && cpu_re;
  assign miss     = idle && req && !slot_hit && !ctrl_hit;
  assign rd_arr   = dev_rd;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    accept    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state)
      IDLE: if (req && slot_hit) begin
        accept    = 1'b1;
        cpu_stall = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (dev_ready[sel]) begin
          finish_ok = 1'b1;
          state_nxt = DONE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          finish_to = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;  // held request is deliberately not reissued
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sel    <= '0;
      dir_we <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rdata  <= '0;
      st_err <= 1'b0;
      st_to  <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        sel    <= slot_idx[SW-1:0];
        dir_we <= cpu_we;
        addr_q <= cpu_addr;
        wd_q   <= cpu_wd;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (finish_ok)      rdata <= rd_arr[sel];
      else if (finish_to) rdata <= '0;
      if (ctrl_we && wofs == 30'd0) begin
        st_err <= 1'b0;
        st_to  <= 1'b0;
      end
      if (miss) st_err <= 1'b1;
      if (finish_to) begin
        st_err <= 1'b1;
        st_to  <= 1'b1;
      end
    end
  end

  // Strobe only in the first WAIT cycle, identified by the fresh counter.
  assign strobe = (state == WAIT) && (cnt == 8'd0);
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_DEV; i++) sel_oh[i] = (sel == SW'(i));
  end
  assign dev_we   = (strobe && dir_we)  ? sel_oh : '0;
  assign dev_re   = (strobe && !dir_we) ? sel_oh : '0;
  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;

`ifdef SYS_BRIDGE_IRQ_LATCH_EN
  logic [N_DEV-1:0] irq_prev, pending, mask, pnd_clr;
  assign pnd_clr = (ctrl_we && wofs == 30'd1) ? cpu_wd[N_DEV-1:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '1;
    end else begin
      irq_prev <= dev_irq;
      pending  <= (pending & ~pnd_clr) | (dev_irq & ~irq_prev);  // edge beats clear
      if (ctrl_we && wofs == 30'd2) mask <= cpu_wd[N_DEV-1:0];
    end
  end
  assign intr_src = pending & mask;
`else
  logic [N_DEV-1:0] irq_q;
  always_ff @(posedge clk) begin
    if (reset) irq_q <= '0;
    else       irq_q <= dev_irq;
  end
  assign intr_src = irq_q;
`endif
  assign cpu_intr = 6'(intr_src);

  always_comb begin
    ctrl_rdata = '0;
    if (wofs == 30'd0) ctrl_rdata = {30'd0, st_to, st_err};
`ifdef SYS_BRIDGE_IRQ_LATCH_EN
    else if (wofs == 30'd1) ctrl_rdata = 32'(pending);
    else if (wofs == 30'd2) ctrl_rdata = 32'(mask);
`endif
  end

  always_comb begin
    cpu_rd = '0;
    if (state == DONE) cpu_rd = rdata;
    else if (ctrl_re)  cpu_rd = ctrl_rdata;
  end
endmodule

// File: tb/tb_sys_bridge_n.sv
// Randomized self-checking bench for sys_bridge_n against a transaction-level model.
// Also covers SYS_BRIDGE_IRQ_LATCH_EN when that macro is defined for the build.
module tb_sys_bridge_n;
  localparam int          N    = 2;
  localparam int          T    = 16;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] CTRL = 32'h0000_7F20;

  logic                clk, reset, cpu_we, cpu_re, cpu_stall;
  logic [31:0]         cpu_addr, cpu_wd, cpu_rd, dev_addr, dev_wd;
  logic [5:0]          cpu_intr;
  logic [N-1:0]        dev_we, dev_re, dev_ready, dev_irq;
  logic [N-1:0][31:0]  drd;

  int   checks = 0, failures = 0;
  logic m_err, m_to;
  logic [N-1:0] m_pend, m_mask;

  sys_bridge_n #(.N_DEV(N), .DEV_BASE(BASE), .SPAN_LOG2(4), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall), .cpu_intr(cpu_intr),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we), .dev_re(dev_re),
    .dev_rd(drd), .dev_ready(dev_ready), .dev_irq(dev_irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_ctrl(input int wo);
    if (wo == 0) return {30'd0, m_to, m_err};
`ifdef SYS_BRIDGE_IRQ_LATCH_EN
    if (wo == 1) return 32'(m_pend);
    if (wo == 2) return 32'(m_mask);
`endif
    return 32'd0;
  endfunction

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wd = '0; dev_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs(); dev_irq = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_err = 1'b0; m_to = 1'b0; m_pend = '0; m_mask = '1;
  endtask

  // One device transaction; ready_at is the cycle (0 = request cycle) in which the selected ready pulses.
  task automatic run_dev(input logic [31:0] addr, input logic we, input logic re, input logic [31:0] wd,
                         input int ready_at, input bit noise, output int stall_n, output logic [31:0] rd_done,
                         output int n_strobe, output int strobe_cyc, output logic [N-1:0] we_seen,
                         output logic [N-1:0] re_seen, output bit done);
    int slot;
    slot = int'((addr - BASE) >> 4);
    stall_n = 0; rd_done = '0; n_strobe = 0; strobe_cyc = -1; we_seen = '0; re_seen = '0; done = 0;
    cpu_addr = addr; cpu_wd = wd; cpu_we = we; cpu_re = re;
    for (int c = 0; c < 300; c++) begin
      dev_ready = '0;
      if (c == ready_at) dev_ready[slot] = 1'b1;
      if (noise && c >= 1 && c <= 3)
        for (int s = 0; s < N; s++) if (s != slot) dev_ready[s] = 1'b1;
      @(negedge clk);
      if ((dev_we | dev_re) != '0) begin
        n_strobe++;
        if (strobe_cyc < 0) strobe_cyc = c;
      end
      we_seen |= dev_we; re_seen |= dev_re;
      if (!cpu_stall) begin
        rd_done = cpu_rd; done = (c > 0);
        break;
      end
      stall_n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic ctrl_rw(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd, output logic st);
    cpu_addr = addr; cpu_we = we; cpu_re = !we; cpu_wd = wd;
    @(negedge clk);
    rd = cpu_rd; st = cpu_stall;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic st;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    checks++; if (cpu_rd !== 32'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", cpu_rd); end
    checks++; if (cpu_intr !== 6'd0) begin failures++; $display("FAIL reset_intr got=%b exp=0", cpu_intr); end
    checks++; if ((dev_we | dev_re) !== '0) begin failures++; $display("FAIL reset_strobe got=%b/%b exp=0", dev_we, dev_re); end
    checks++; if ({dev_addr, dev_wd} !== 64'd0) begin failures++; $display("FAIL reset_dev_addr_wd got=%h/%h exp=0", dev_addr, dev_wd); end
    @(posedge clk); #1;
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", rd); end
`ifdef SYS_BRIDGE_IRQ_LATCH_EN
    ctrl_rw(CTRL + 32'd8, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL reset_mask got=%h exp=3", rd); end
`endif
  endtask

  task automatic test_read_zero_wait();
    int sn, ns, sc; logic [31:0] rd; logic [N-1:0] ws, rs; bit dn;
    drd[0] = 32'hDEAD_0000; drd[1] = 32'h1234_5678;
    run_dev(BASE + 32'h10, 1'b0, 1'b1, '0, 1, 0, sn, rd, ns, sc, ws, rs, dn);
    checks++; if (!dn) begin failures++; $display("FAIL zw_done got=0 exp=1"); end
    checks++; if (sn != 2) begin failures++; $display("FAIL zw_stall got=%0d exp=2", sn); end
    checks++; if (rs !== 2'b10 || ws !== 2'b00) begin failures++; $display("FAIL zw_strobe got re=%b we=%b exp re=10 we=00", rs, ws); end
    checks++; if (ns != 1 || sc != 1) begin failures++; $display("FAIL zw_strobe_len got=%0d@%0d exp=1@1", ns, sc); end
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL zw_rd got=%h exp=12345678", rd); end
  endtask

  task automatic test_write_wait();
    int sn, ns, sc; logic [31:0] rd; logic [N-1:0] ws, rs; bit dn;
    drd[0] = 32'h0BAD_F00D;
    run_dev(BASE + 32'h4, 1'b1, 1'b0, 32'hA5A5_0001, 5, 0, sn, rd, ns, sc, ws, rs, dn);
    checks++; if (sn != 6 || !dn) begin failures++; $display("FAIL wr_stall got=%0d done=%0d exp=6 done=1", sn, dn); end
    checks++; if (ws !== 2'b01 || rs !== 2'b00 || ns != 1) begin failures++; $display("FAIL wr_strobe got we=%b re=%b n=%0d exp we=01 re=00 n=1", ws, rs, ns); end
    checks++; if (dev_addr !== 32'h7F04) begin failures++; $display("FAIL wr_dev_addr got=%h exp=7f04", dev_addr); end
    checks++; if (dev_wd !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_dev_wd got=%h exp=a5a50001", dev_wd); end
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL wr_rdata got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_timeout();
    int sn, ns, sc; logic [31:0] rd; logic [N-1:0] ws, rs; bit dn; logic st;
    drd[0] = 32'hFFFF_FFFF;
    run_dev(BASE, 1'b0, 1'b1, '0, -1, 1, sn, rd, ns, sc, ws, rs, dn);
    m_err = 1'b1; m_to = 1'b1;
    checks++; if (sn != T + 1 || !dn) begin failures++; $display("FAIL to_stall got=%0d exp=%0d", sn, T + 1); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL to_rd got=%h exp=0", rd); end
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd3 || st !== 1'b0) begin failures++; $display("FAIL to_status got=%h stall=%b exp=3 stall=0", rd, st); end
    ctrl_rw(CTRL, 1'b1, 32'h0, rd, st);
    m_err = 1'b0; m_to = 1'b0;
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL to_status_clr got=%h exp=0", rd); end
  endtask

  task automatic test_miss();
    logic [31:0] rd; logic st;
    ctrl_rw(32'h0000_1000, 1'b0, '0, rd, st);
    m_err = 1'b1;
    checks++; if (st !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL miss_rd got=%h stall=%b exp=0 stall=0", rd, st); end
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL miss_status got=%h exp=1", rd); end
    ctrl_rw(CTRL + 32'hC, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd0 || st !== 1'b0) begin failures++; $display("FAIL ctrl_ofs3 got=%h exp=0", rd); end
    ctrl_rw(CTRL, 1'b1, 32'hFFFF_FFFF, rd, st);
    m_err = 1'b0;
  endtask

  task automatic test_ready_boundary();
    int sn, ns, sc; logic [31:0] rd; logic [N-1:0] ws, rs; bit dn; logic st;
    drd[1] = 32'hCAFE_0001;
    run_dev(BASE + 32'h10, 1'b1, 1'b1, 32'h55, T, 0, sn, rd, ns, sc, ws, rs, dn);
    checks++; if (sn != T + 1 || rd !== 32'hCAFE_0001) begin failures++; $display("FAIL bnd_last_cycle got=%0d/%h exp=%0d/cafe0001", sn, rd, T + 1); end
    checks++; if (ws !== 2'b10 || rs !== 2'b00) begin failures++; $display("FAIL bnd_we_priority got we=%b re=%b exp we=10 re=00", ws, rs); end
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL bnd_no_err got=%h exp=0", rd); end
    run_dev(BASE + 32'h10, 1'b0, 1'b1, '0, 0, 0, sn, rd, ns, sc, ws, rs, dn);
    m_err = 1'b1; m_to = 1'b1;
    checks++; if (sn != T + 1 || rd !== 32'd0) begin failures++; $display("FAIL bnd_ready_in_idle got=%0d/%h exp=%0d/0", sn, rd, T + 1); end
    ctrl_rw(CTRL, 1'b1, '0, rd, st);
    m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic st;
    drd[0] = 32'h7777_7777;
    cpu_addr = BASE; cpu_re = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0; m_err = 1'b0; m_to = 1'b0; m_pend = '0; m_mask = '1;
    dev_ready[0] = 1'b1;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || dev_re !== '0) begin failures++; $display("FAIL rstmid_idle got stall=%b re=%b exp 0", cpu_stall, dev_re); end
    @(posedge clk); #1;
    dev_ready = '0;
    @(negedge clk);
    checks++; if (cpu_rd !== 32'd0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got rd=%h stall=%b exp 0", cpu_rd, cpu_stall); end
    checks++; if (dev_addr !== 32'd0) begin failures++; $display("FAIL rstmid_dev_addr got=%h exp=0", dev_addr); end
    @(posedge clk); #1;
    ctrl_rw(CTRL, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rstmid_status got=%h exp=0", rd); end
  endtask

  task automatic test_random();
    int sn, ns, sc, slot, ra, wo, exp_sn; logic [31:0] addr, wd, rd, exp_rd, last_a, last_w;
    logic [N-1:0] ws, rs, exp_oh; bit dn, to, have; logic we, re, st, noise;
    have = 0; last_a = '0; last_w = '0;
    for (int it = 0; it < 48; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          slot = $urandom_range(0, N - 1);
          addr = BASE + 32'(slot) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
          wd = $urandom; we = 1'($urandom_range(0, 1)); re = we ? 1'($urandom_range(0, 1)) : 1'b1;
          case ($urandom_range(0, 3))
            0: ra = $urandom_range(1, 3);
            1: ra = $urandom_range(4, T + 2);
            2: ra = -1;
            default: ra = $urandom_range(0, 1) ? T : 0;
          endcase
          noise = 1'($urandom_range(0, 1));
          drd[0] = $urandom; drd[1] = $urandom;
          run_dev(addr, we, re, wd, ra, noise, sn, rd, ns, sc, ws, rs, dn);
          to = !(ra >= 1 && ra <= T);
          exp_sn = to ? T + 1 : ra + 1;
          exp_rd = to ? 32'd0 : drd[slot];
          exp_oh = '0; exp_oh[slot] = 1'b1;
          checks++; if (sn != exp_sn || !dn) begin failures++; $display("FAIL rnd_stall it=%0d got=%0d exp=%0d", it, sn, exp_sn); end
          checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rd it=%0d got=%h exp=%h", it, rd, exp_rd); end
          checks++; if (ns != 1 || sc != 1 || ws !== (we ? exp_oh : '0) || rs !== (we ? '0 : exp_oh))
            begin failures++; $display("FAIL rnd_strobe it=%0d got n=%0d@%0d we=%b re=%b", it, ns, sc, ws, rs); end
          checks++; if (dev_addr !== addr || dev_wd !== wd) begin failures++; $display("FAIL rnd_latch it=%0d got=%h/%h exp=%h/%h", it, dev_addr, dev_wd, addr, wd); end
          if (to) begin m_err = 1'b1; m_to = 1'b1; end
          last_a = addr; last_w = wd; have = 1;
        end
        2: begin
          we = 1'($urandom_range(0, 1));
          wo = we ? 3 * $urandom_range(0, 1) : $urandom_range(0, 3);
          ctrl_rw(CTRL + 32'(wo) * 32'd4, we, $urandom, rd, st);
          checks++; if (st !== 1'b0) begin failures++; $display("FAIL rnd_ctrl_stall it=%0d got=%b exp=0", it, st); end
          if (!we) begin
            checks++; if (rd !== exp_ctrl(wo)) begin failures++; $display("FAIL rnd_ctrl_rd it=%0d ofs=%0d got=%h exp=%h", it, wo, rd, exp_ctrl(wo)); end
          end else if (wo == 0) begin
            m_err = 1'b0; m_to = 1'b0;
          end
        end
        default: begin
          addr = $urandom_range(0, 1) ? $urandom_range(0, 32'h7EFF) : $urandom_range(32'h7F30, 32'hFFFF_FFFF);
          we = 1'($urandom_range(0, 1));
          ctrl_rw(addr, we, $urandom, rd, st);
          m_err = 1'b1;
          checks++; if (st !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL rnd_miss it=%0d got=%h stall=%b exp=0", it, rd, st); end
          if (have) begin
            checks++; if (dev_addr !== last_a || dev_wd !== last_w) begin failures++; $display("FAIL rnd_miss_latch it=%0d got=%h exp=%h", it, dev_addr, last_a); end
          end
        end
      endcase
      if (it % 8 == 7) begin
        ctrl_rw(CTRL, 1'b0, '0, rd, st);
        checks++; if (rd !== exp_ctrl(0)) begin failures++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, rd, exp_ctrl(0)); end
      end
    end
  endtask

`ifdef SYS_BRIDGE_IRQ_LATCH_EN
  task automatic test_intr();
    logic [31:0] rd; logic st; logic [N-1:0] irq, prv, clr; int op;
    dev_irq = 2'b01;
    @(posedge clk); #1;
    dev_irq = 2'b00;
    repeat (3) @(posedge clk); #1;
    m_pend = 2'b01;
    @(negedge clk);
    checks++; if (cpu_intr !== 6'b000001) begin failures++; $display("FAIL irq_latched got=%b exp=000001", cpu_intr); end
    @(posedge clk); #1;
    ctrl_rw(CTRL + 32'd8, 1'b1, 32'd0, rd, st);
    m_mask = '0;
    @(negedge clk);
    checks++; if (cpu_intr !== 6'd0) begin failures++; $display("FAIL irq_masked got=%b exp=0", cpu_intr); end
    @(posedge clk); #1;
    ctrl_rw(CTRL + 32'd4, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL irq_pend_masked got=%h exp=1", rd); end
    ctrl_rw(CTRL + 32'd8, 1'b1, 32'd3, rd, st);
    m_mask = '1;
    ctrl_rw(CTRL + 32'd4, 1'b1, 32'd1, rd, st);
    m_pend = '0;
    @(negedge clk);
    checks++; if (cpu_intr !== 6'd0) begin failures++; $display("FAIL irq_cleared got=%b exp=0", cpu_intr); end
    @(posedge clk); #1;
    dev_irq = 2'b10; cpu_addr = CTRL + 32'd4; cpu_we = 1'b1; cpu_wd = 32'd2;
    @(posedge clk); #1;
    idle_inputs(); m_pend = 2'b10;
    ctrl_rw(CTRL + 32'd4, 1'b0, '0, rd, st);
    checks++; if (rd !== 32'd2) begin failures++; $display("FAIL irq_edge_wins got=%h exp=2", rd); end
    prv = dev_irq;
    for (int c = 0; c < 40; c++) begin
      irq = N'($urandom_range(0, 3)); op = $urandom_range(0, 5); clr = '0;
      dev_irq = irq;
      if (op == 0) begin cpu_addr = CTRL + 32'd4; cpu_we = 1'b1; cpu_wd = $urandom; clr = cpu_wd[N-1:0]; end
      else if (op == 1) begin cpu_addr = CTRL + 32'd8; cpu_we = 1'b1; cpu_wd = $urandom; end
      else if (op == 2) begin cpu_addr = CTRL + 32'd4; cpu_re = 1'b1; end
      @(negedge clk);
      checks++; if (cpu_intr !== 6'(m_pend & m_mask)) begin failures++; $display("FAIL irq_rnd c=%0d got=%b exp=%b", c, cpu_intr, 6'(m_pend & m_mask)); end
      if (op == 2) begin
        checks++; if (cpu_rd !== 32'(m_pend)) begin failures++; $display("FAIL irq_rnd_pend c=%0d got=%h exp=%h", c, cpu_rd, 32'(m_pend)); end
      end
      m_pend = (m_pend & ~clr) | (irq & ~prv);
      if (op == 1) m_mask = cpu_wd[N-1:0];
      prv = irq;
      @(posedge clk); #1;
      idle_inputs();
    end
    dev_irq = '0;
  endtask
`else
  task automatic test_intr();
    logic [N-1:0] prv;
    dev_irq = 2'b01;
    @(negedge clk);
    checks++; if (cpu_intr !== 6'd0) begin failures++; $display("FAIL irq_delay got=%b exp=0", cpu_intr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_intr !== 6'b000001) begin failures++; $display("FAIL irq_level got=%b exp=000001", cpu_intr); end
    @(posedge clk); #1;
    for (int c = 0; c < 24; c++) begin
      prv = dev_irq;
      dev_irq = N'($urandom_range(0, 3));
      @(negedge clk);
      checks++; if (cpu_intr !== 6'(prv)) begin failures++; $display("FAIL irq_rnd c=%0d got=%b exp=%b", c, cpu_intr, 6'(prv)); end
      @(posedge clk); #1;
    end
    dev_irq = '0;
  endtask
`endif

  initial begin
    reset = 1'b1; idle_inputs(); dev_irq = '0; drd = '0;
    do_reset();
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_miss();
    test_ready_boundary();
    test_reset_mid();
    test_random();
    test_intr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
Parametrised system bridge between the CPU data port and up to six memory-mapped devices. Generalises the fixed two-port bridge:
- N_DEV device slots with address decode.
- Per-device ready handshake, with CPU stall for wait states.
- Bus timeout with error status.
- Interrupt aggregation onto the 6-bit CPU interrupt vector.

Sits between cpu and the peripheral set inside the mips top.

Parameters:
N_DEV, 2, number of device slots (1..6)
DEV_BASE, 32'h0000_7F00, byte address of slot 0; word aligned to 2^SPAN_LOG2
SPAN_LOG2, 4, log2 of bytes per slot; slot i = DEV_BASE + i*2^SPAN_LOG2
TIMEOUT, 16, WAIT cycles without dev_ready before abort (2..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_addr  input  32  CPU byte address
cpu_wd  input  32  CPU write data
cpu_we  input  1  CPU write request
cpu_re  input  1  CPU read request
cpu_rd  output  32  read data to CPU
cpu_stall  output  1  CPU must hold request and freeze
cpu_intr  output  6  interrupt vector to CPU
dev_addr  output  32  latched address, shared by all slots
dev_wd  output  32  latched write data, shared
dev_we  output  N_DEV  one-hot write strobe
dev_re  output  N_DEV  one-hot read strobe
dev_rd  input  32*N_DEV  read data; slot i at [32*i+31:32*i]
dev_ready  input  N_DEV  slot completion pulse
dev_irq  input  N_DEV  level interrupt from slot

Behaviour:
- Decode:
  - hit[i] when cpu_addr is within slot i.
  - ctrl hit when cpu_addr is within DEV_BASE + N_DEV*2^SPAN_LOG2 (bridge's own region).
  - All other addresses: miss.
  - cpu_we has priority if both cpu_we and cpu_re are high.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Request with slot hit: latch addr/wd/slot/dir, go WAIT, cpu_stall=1 combinationally in this cycle.
  - Ctrl hit: zero-latency register access, no stall.
  - Miss: no stall; cpu_rd=0; write ignored; status.err<=1.
- WAIT:
  - The selected strobe (dev_we[i] or dev_re[i]) is high only in the first WAIT cycle.
  - cpu_stall=1 throughout.
  - dev_ready[sel] is sampled every WAIT cycle, including the strobe cycle. On ready: capture dev_rd[sel] into rdata, go DONE.
  - Timeout counter starts at 0 on WAIT entry and increments each cycle. When it reaches TIMEOUT-1 without ready: rdata<=0, status.err<=1, status.to<=1, go DONE.
  - dev_ready on unselected slots is ignored.
- DONE:
  - Lasts exactly one cycle.
  - cpu_stall=0; cpu_rd=rdata.
  - Next state is IDLE; the still-held request is not reissued.
- Latency: zero-wait device = request cycle + 1 WAIT + 1 DONE, i.e. 2 stall cycles.
- dev_addr/dev_wd hold their latched values until the next accepted request.
- Control registers (word offset within ctrl region):
  - 0 STATUS, RO: bit0 err, bit1 to, others 0. Any write clears both bits.
  - Other offsets read 0; writes ignored.
- Interrupts: cpu_intr[i] = dev_irq[i] registered one cycle, for i < N_DEV. Bits N_DEV..5 are 0.
- Reset (including mid-transaction):
  - FSM to IDLE; strobes and cpu_stall 0.
  - cpu_rd 0; rdata 0; status 0; cpu_intr 0; dev_addr/dev_wd 0.
  - A device's late dev_ready after reset is ignored.

Optional Feature:
Macro SYS_BRIDGE_IRQ_LATCH_EN.
- Defined:
  - Rising edge of dev_irq[i] sets pending[i]; a pending bit holds until cleared.
  - cpu_intr[i] = pending[i] & mask[i].
  - Ctrl offset 1 PENDING: read returns pending; write-1-to-clear. An edge in the same cycle wins over the clear.
  - Ctrl offset 2 MASK: RW; resets to all ones over N_DEV bits.
- Undefined: level-registered behaviour as above; offsets 1 and 2 read 0 and writes are ignored.

Test Plan:
- N_DEV=2. Read 0x7F10 with dev_ready[1] pulsed in the strobe cycle -> dev_re=2'b10 for 1 cycle, cpu_stall high 2 cycles, cpu_rd=dev_rd[63:32]=0x1234_5678 in the DONE cycle.
- Write 0x7F04 data 0xA5A5_0001, dev_ready[0] delayed 5 cycles -> dev_we[0] high 1 cycle, dev_addr=0x7F04, dev_wd=0xA5A5_0001, stall 6 cycles.
- Read 0x7F00 with dev_ready held low, TIMEOUT=16 -> stall ends after 16 WAIT cycles, cpu_rd=0, STATUS read at 0x7F20 = 3. Write 0x7F20 -> STATUS reads 0.
- Read 0x0000_1000 (miss) -> no stall, cpu_rd=0, STATUS=1.
- Assert reset in the 2nd WAIT cycle -> next cycle IDLE, cpu_stall=0. dev_ready pulsed afterwards causes no DONE.
- Interrupts:
  - Without the macro: dev_irq=2'b01 -> cpu_intr=6'b000001 one cycle later.
  - With the macro: a 1-cycle irq pulse keeps cpu_intr[0]=1 until a write of 1 to 0x7F24. With MASK=0 at 0x7F28, cpu_intr=0 while PENDING still reads 1.
